// File: rtl/usbh_hid_report_mux.sv
// Purpose: capture per-port HID reports and forward changed ones on one tagged valid/ready stream.
// Latency: hid_valid at edge t -> grant at t+1 -> out_valid visible after t+1 (2 cycles).
// Backpressure: output held stable while out_ready=0; a newer report replaces the pending one and sets overrun.
// Optional liveness timeout is built when HID_MUX_TIMEOUT_EN is defined.
module usbh_hid_report_mux #(
  parameter  int C_channels       = 3,
  parameter  int C_report_bytes   = 20,
  parameter  int C_disp_bytes     = 8,
  parameter  int C_timeout_cycles = 6000000,
  localparam int CW = (C_channels > 1) ? $clog2(C_channels) : 1,
  localparam int R8 = C_report_bytes * 8,
  localparam int D8 = C_disp_bytes * 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [C_channels*R8-1:0]   hid_report,
  input  logic [C_channels-1:0]      hid_valid,
  output logic [R8-1:0]              out_report,
  output logic [CW-1:0]              out_channel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [C_channels*D8-1:0]   disp,
  output logic [C_channels-1:0]      alive,
  output logic [C_channels-1:0]      overrun
);

  if (C_channels < 1 || C_channels > 8 || C_disp_bytes > C_report_bytes ||
      C_disp_bytes < 1 || C_timeout_cycles < 2) begin : g_param_err
    $error("usbh_hid_report_mux: illegal parameter combination");
  end

  typedef enum logic {S_IDLE, S_PRESENT} state_e;

  state_e                  state_q, state_d;
  logic [R8-1:0]           hold_q   [C_channels];
  logic [R8-1:0]           hold_d   [C_channels];
  logic [R8-1:0]           shadow_q [C_channels];
  logic [R8-1:0]           shadow_d [C_channels];
  logic [R8-1:0]           in_slice [C_channels];
  logic [C_channels-1:0]   pending_q, pending_d;
  logic [C_channels-1:0]   shadow_ok_q, shadow_ok_d;
  logic [C_channels-1:0]   alive_q, alive_d;
  logic [C_channels-1:0]   overrun_q, overrun_d;
  logic [C_channels*D8-1:0] disp_q, disp_d;
  logic [R8-1:0]           out_report_q, out_report_d;
  logic [CW-1:0]           out_channel_q, out_channel_d;
  logic [CW-1:0]           last_grant_q, last_grant_d;
  logic                    grant_found;
  logic [CW-1:0]           grant_idx;
  logic                    do_grant;
  logic [C_channels-1:0]   timeout_hit;

  // Split the flat input bus into per-channel report slices.
  always_comb begin
    for (int i = 0; i < C_channels; i++) begin
      in_slice[i] = hid_report[i*R8 +: R8];
    end
  end

  // Round-robin search: first pending channel after last_grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= C_channels; k++) begin
      if (!grant_found && pending_q[(int'(last_grant_q) + k) % C_channels]) begin
        grant_found = 1'b1;
        grant_idx   = CW'((int'(last_grant_q) + k) % C_channels);
      end
    end
  end

  // Arbiter FSM: grant from IDLE, or back-to-back on a handshake in PRESENT.
  always_comb begin
    state_d       = state_q;
    out_report_d  = out_report_q;
    out_channel_d = out_channel_q;
    last_grant_d  = last_grant_q;
    do_grant      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          do_grant = 1'b1;
          state_d  = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          do_grant = grant_found;
          state_d  = grant_found ? S_PRESENT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_grant) begin
      out_report_d  = hold_q[grant_idx];
      out_channel_d = grant_idx;
      last_grant_d  = grant_idx;
    end
  end

  // Per-channel capture: grant effects first, so a same-cycle report is
  // compared against the value that was just forwarded.
  always_comb begin
    hold_d      = hold_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    shadow_ok_d = shadow_ok_q;
    disp_d      = disp_q;
    alive_d     = alive_q;
    overrun_d   = overrun_q;
    for (int i = 0; i < C_channels; i++) begin
      if (do_grant && (int'(grant_idx) == i)) begin
        shadow_d[i]    = hold_q[i];
        shadow_ok_d[i] = 1'b1;
        pending_d[i]   = 1'b0;
      end
      if (hid_valid[i]) begin
        hold_d[i]             = in_slice[i];
        disp_d[i*D8 +: D8]    = in_slice[i][D8-1:0];
        alive_d[i]            = 1'b1;
        if (!shadow_ok_d[i] || (in_slice[i] != shadow_d[i])) begin
          pending_d[i] = 1'b1;
        end
        if (pending_q[i] && !(do_grant && (int'(grant_idx) == i))) begin
          overrun_d[i] = 1'b1;
        end
      end
      if (timeout_hit[i]) begin
        alive_d[i]         = 1'b0;
        shadow_ok_d[i]     = 1'b0;
        pending_d[i]       = 1'b0;
        disp_d[i*D8 +: D8] = '0;
      end
    end
  end

`ifdef HID_MUX_TIMEOUT_EN
  localparam int            TW  = $clog2(C_timeout_cycles);
  localparam logic [TW-1:0] LIM = TW'(C_timeout_cycles - 1);

  logic [TW-1:0] cnt_q [C_channels];
  logic [TW-1:0] cnt_d [C_channels];

  // Silence counters: cleared by a report, saturate at the limit.
  always_comb begin
    for (int i = 0; i < C_channels; i++) begin
      if (hid_valid[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LIM) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + TW'(1);
      end
      timeout_hit[i] = (cnt_q[i] == LIM) && !hid_valid[i];
    end
  end

  // Silence counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < C_channels; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < C_channels; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign timeout_hit = '0;
`endif

  // State registers for arbiter, capture and output stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      out_report_q  <= '0;
      out_channel_q <= '0;
      last_grant_q  <= CW'(C_channels - 1);
      pending_q     <= '0;
      shadow_ok_q   <= '0;
      alive_q       <= '0;
      overrun_q     <= '0;
      disp_q        <= '0;
      for (int i = 0; i < C_channels; i++) begin
        hold_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      out_report_q  <= out_report_d;
      out_channel_q <= out_channel_d;
      last_grant_q  <= last_grant_d;
      pending_q     <= pending_d;
      shadow_ok_q   <= shadow_ok_d;
      alive_q       <= alive_d;
      overrun_q     <= overrun_d;
      disp_q        <= disp_d;
      for (int i = 0; i < C_channels; i++) begin
        hold_q[i]   <= hold_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign out_valid   = (state_q == S_PRESENT);
  assign out_report  = out_report_q;
  assign out_channel = out_channel_q;
  assign disp        = disp_q;
  assign alive       = alive_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_usbh_hid_report_mux.sv
// Purpose: directed checks of the HID report mux with 3 channels and 20-byte reports.
// Latency: checks sampled at the falling edge after each driven rising edge.
// Backpressure: exercised by holding out_ready low during the overrun sequence.
module tb_usbh_hid_report_mux;

  logic         clk;
  logic         resetn;
  logic [479:0] hid_report;
  logic [2:0]   hid_valid;
  logic [159:0] out_report;
  logic [1:0]   out_channel;
  logic         out_valid;
  logic         out_ready;
  logic [191:0] disp;
  logic [2:0]   alive;
  logic [2:0]   overrun;

  int checks = 0;
  int errors = 0;

  usbh_hid_report_mux #(
    .C_channels(3), .C_report_bytes(20), .C_disp_bytes(8), .C_timeout_cycles(16)
  ) dut (
    .clk(clk), .resetn(resetn), .hid_report(hid_report), .hid_valid(hid_valid),
    .out_report(out_report), .out_channel(out_channel), .out_valid(out_valid),
    .out_ready(out_ready), .disp(disp), .alive(alive), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  vld;
    logic [15:0] d0, d1, d2;
    logic        rdy;
    logic        ov;
    logic [1:0]  ch;
    logic [15:0] rep;
    logic [2:0]  al;
    logic [15:0] e0, e1, e2;
  } vec_t;

  vec_t vec [22];

  function automatic logic [159:0] rep16(input logic [15:0] d);
    return {144'h0, d};
  endfunction

  function automatic logic [191:0] dispx(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return {48'h0, c, 48'h0, b, 48'h0, a};
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and return at the following falling edge.
  task automatic cycle(input logic [2:0] v, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic rdy);
    hid_valid  = v;
    hid_report = {rep16(c), rep16(b), rep16(a)};
    out_ready  = rdy;
    @(posedge clk);
    @(negedge clk);
    hid_valid  = 3'b000;
  endtask

  task automatic check_out(input string name, input logic ov, input logic [1:0] ch, input logic [15:0] r);
    check({name, " out_valid"}, 192'(out_valid), 192'(ov));
    if (ov) begin
      check({name, " out_channel"}, 192'(out_channel), 192'(ch));
      check({name, " out_report"}, 192'(out_report), 192'(rep16(r)));
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check("reset out_valid", 192'(out_valid), 192'(0));
    check("reset alive", 192'(alive), 192'(0));
    check("reset overrun", 192'(overrun), 192'(0));
    check("reset disp", disp, 192'(0));
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn     = 1'b0;
    hid_valid  = 3'b000;
    hid_report = '0;
    out_ready  = 1'b1;

    //           vld     d0       d1       d2       rdy ov ch     rep      al      e0       e1       e2
    vec[0]  = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 0, 2'd0, 16'h0,   3'b000, 16'h0,   16'h0,   16'h0};
    vec[1]  = '{3'b010, 16'h0,   16'h0102,16'h0,   1, 0, 2'd0, 16'h0,   3'b010, 16'h0,   16'h0102,16'h0};
    vec[2]  = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 1, 2'd1, 16'h0102,3'b010, 16'h0,   16'h0102,16'h0};
    vec[3]  = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 0, 2'd0, 16'h0,   3'b010, 16'h0,   16'h0102,16'h0};
    vec[4]  = '{3'b001, 16'h00AA,16'h0,   16'h0,   1, 0, 2'd0, 16'h0,   3'b011, 16'h00AA,16'h0102,16'h0};
    vec[5]  = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 1, 2'd0, 16'h00AA,3'b011, 16'h00AA,16'h0102,16'h0};
    vec[6]  = '{3'b001, 16'h00AA,16'h0,   16'h0,   1, 0, 2'd0, 16'h0,   3'b011, 16'h00AA,16'h0102,16'h0};
    vec[7]  = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 0, 2'd0, 16'h0,   3'b011, 16'h00AA,16'h0102,16'h0};
    vec[8]  = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 0, 2'd0, 16'h0,   3'b011, 16'h00AA,16'h0102,16'h0};
    vec[9]  = '{3'b111, 16'h0A01,16'h0B01,16'h0C01,1, 0, 2'd0, 16'h0,   3'b111, 16'h0A01,16'h0B01,16'h0C01};
    vec[10] = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 1, 2'd1, 16'h0B01,3'b111, 16'h0A01,16'h0B01,16'h0C01};
    vec[11] = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 1, 2'd2, 16'h0C01,3'b111, 16'h0A01,16'h0B01,16'h0C01};
    vec[12] = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 1, 2'd0, 16'h0A01,3'b111, 16'h0A01,16'h0B01,16'h0C01};
    vec[13] = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 0, 2'd0, 16'h0,   3'b111, 16'h0A01,16'h0B01,16'h0C01};
    vec[14] = '{3'b100, 16'h0,   16'h0,   16'h0C02,1, 0, 2'd0, 16'h0,   3'b111, 16'h0A01,16'h0B01,16'h0C02};
    vec[15] = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 1, 2'd2, 16'h0C02,3'b111, 16'h0A01,16'h0B01,16'h0C02};
    vec[16] = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 0, 2'd0, 16'h0,   3'b111, 16'h0A01,16'h0B01,16'h0C02};
    vec[17] = '{3'b111, 16'h0A02,16'h0B02,16'h0C03,1, 0, 2'd0, 16'h0,   3'b111, 16'h0A02,16'h0B02,16'h0C03};
    vec[18] = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 1, 2'd0, 16'h0A02,3'b111, 16'h0A02,16'h0B02,16'h0C03};
    vec[19] = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 1, 2'd1, 16'h0B02,3'b111, 16'h0A02,16'h0B02,16'h0C03};
    vec[20] = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 1, 2'd2, 16'h0C03,3'b111, 16'h0A02,16'h0B02,16'h0C03};
    vec[21] = '{3'b000, 16'h0,   16'h0,   16'h0,   1, 0, 2'd0, 16'h0,   3'b111, 16'h0A02,16'h0B02,16'h0C03};

    repeat (2) @(negedge clk);
    do_reset();

    // Table: first report latency, duplicate drop, round-robin ordering.
    for (int i = 0; i < 22; i++) begin
      cycle(vec[i].vld, vec[i].d0, vec[i].d1, vec[i].d2, vec[i].rdy);
      check_out($sformatf("v%0d", i), vec[i].ov, vec[i].ch, vec[i].rep);
      check($sformatf("v%0d alive", i), 192'(alive), 192'(vec[i].al));
      check($sformatf("v%0d overrun", i), 192'(overrun), 192'(0));
      check($sformatf("v%0d disp", i), disp, dispx(vec[i].e0, vec[i].e1, vec[i].e2));
    end

    // Backpressure: three reports on ch2 while the stream is stalled.
    cycle(3'b100, 16'h0, 16'h0, 16'h0D01, 1'b0);
    cycle(3'b000, 16'h0, 16'h0, 16'h0,    1'b0);
    check_out("ovr grant", 1'b1, 2'd2, 16'h0D01);
    cycle(3'b100, 16'h0, 16'h0, 16'h0D02, 1'b0);
    check_out("ovr stall1", 1'b1, 2'd2, 16'h0D01);
    check("ovr stall1 overrun", 192'(overrun), 192'(0));
    cycle(3'b100, 16'h0, 16'h0, 16'h0D03, 1'b0);
    check_out("ovr stall2", 1'b1, 2'd2, 16'h0D01);
    check("ovr stall2 overrun", 192'(overrun), 192'(3'b100));
    cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check_out("ovr release", 1'b1, 2'd2, 16'h0D03);
    check("ovr disp", disp, dispx(16'h0A02, 16'h0B02, 16'h0D03));
    cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check_out("ovr drain", 1'b0, 2'd0, 16'h0);
    check("ovr sticky", 192'(overrun), 192'(3'b100));

    // Report on the channel being granted in the same cycle.
    do_reset();
    cycle(3'b001, 16'h1111, 16'h0, 16'h0, 1'b1);
    cycle(3'b001, 16'h2222, 16'h0, 16'h0, 1'b1);
    check_out("same grant1", 1'b1, 2'd0, 16'h1111);
    cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check_out("same grant2", 1'b1, 2'd0, 16'h2222);
    cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check_out("same idle", 1'b0, 2'd0, 16'h0);
    check("same overrun", 192'(overrun), 192'(0));

    // Reset asserted while a transfer is presented.
    cycle(3'b010, 16'h0, 16'h3333, 16'h0, 1'b0);
    cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b0);
    check_out("midrst before", 1'b1, 2'd1, 16'h3333);
    #2 resetn = 1'b0;
    #1;
    check("midrst out_valid", 192'(out_valid), 192'(0));
    check("midrst out_report", 192'(out_report), 192'(0));
    check("midrst alive", 192'(alive), 192'(0));
    @(negedge clk);
    resetn = 1'b1;

`ifdef HID_MUX_TIMEOUT_EN
    // Liveness timeout after 16 silent cycles; identical report forwarded again.
    cycle(3'b001, 16'h4444, 16'h0, 16'h0, 1'b1);
    cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check_out("to first", 1'b1, 2'd0, 16'h4444);
    repeat (14) cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check("to alive t+15", 192'(alive), 192'(3'b001));
    cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check("to alive t+16", 192'(alive), 192'(0));
    check("to disp", disp, 192'(0));
    cycle(3'b001, 16'h4444, 16'h0, 16'h0, 1'b1);
    cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check_out("to resend", 1'b1, 2'd0, 16'h4444);
`else
    // Without the timeout, a silent channel stays alive and keeps its display.
    cycle(3'b001, 16'h4444, 16'h0, 16'h0, 1'b1);
    cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check_out("nto first", 1'b1, 2'd0, 16'h4444);
    repeat (30) cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check("nto alive", 192'(alive), 192'(3'b001));
    check("nto disp", disp, dispx(16'h4444, 16'h0, 16'h0));
    cycle(3'b001, 16'h4444, 16'h0, 16'h0, 1'b1);
    cycle(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check_out("nto dup dropped", 1'b0, 2'd0, 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
